// File: rtl/uart_tx_buffer_if.sv
// Byte-queue and transmitter handshake bundle
// for the buffered UART transmit source.
interface uart_tx_buffer_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                wr_en;
  logic [7:0]          wr_data;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;
  logic                busy;
  logic                new_data_tx;
  logic [7:0]          data_tx;

  modport master (
    output wr_en,
    output wr_data,
    output busy,
    input  full,
    input  empty,
    input  count,
    input  overflow,
    input  new_data_tx,
    input  data_tx
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    input  busy,
    output full,
    output empty,
    output count,
    output overflow,
    output new_data_tx,
    output data_tx
  );
endinterface

// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding the serial transmitter one
// start pulse at a time, with a busy-ack window.
module uart_tx_buffer #(
  parameter int DEPTH_LOG2  = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_buffer_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int TW    =
    (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] T_LAST =
    TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [TW-1:0]         r_timer;
  logic [TW-1:0]         w_timer_nxt;
  logic                  r_overflow;
  logic                  r_new_data;
  logic [7:0]            r_data_tx;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_push  = bus.wr_en && !w_full;

  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.count       = r_count;
  assign bus.overflow    = r_overflow;
  assign bus.new_data_tx = r_new_data;
  assign bus.data_tx     = r_data_tx;

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = '0;
    w_pop       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty && !bus.busy) begin
          w_pop       = 1'b1;
          w_state_nxt = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        // no ack inside the window: byte counts as sent
        if (bus.busy)
          w_state_nxt = S_WAIT_DONE;
        else if (r_timer == T_LAST)
          w_state_nxt = S_IDLE;
        else
          w_timer_nxt = r_timer + 1'b1;
      end
      S_WAIT_DONE: begin
        if (!bus.busy)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_new_data <= 1'b0;
      r_data_tx  <= 8'h00;
    end else begin
      r_overflow <= bus.wr_en && w_full;
      r_new_data <= w_pop;
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_data_tx <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_buffer.sv
// Scoreboard bench for uart_tx_buffer: queued bytes
// are matched against observed start pulses.
module tb_uart_tx_buffer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_buffer_if #(.DEPTH_LOG2(4)) bus ();

  uart_tx_buffer #(
    .DEPTH_LOG2 (4),
    .ACK_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  logic [7:0] exp_q [$];
  logic [7:0] exp_b;

  logic auto_tx   = 1'b0;
  logic busy_lvl  = 1'b0;
  logic auto_busy = 1'b0;
  assign bus.busy = auto_tx ? auto_busy : busy_lvl;

  logic [7:0] got_data [$];
  int         got_cyc  [$];
  int         got_gap  [$];
  int         gi        = 0;
  int         pulse_cnt = 0;
  int         tx_left   = 0;
  int         fall_cyc  = 0;
  bit         have_fall = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // pulse recorder plus a simple transmitter model
  always @(negedge clk) begin
    if (!auto_tx) begin
      auto_busy = 1'b0;
      tx_left   = 0;
      have_fall = 1'b0;
    end
    if (bus.new_data_tx === 1'b1) begin
      pulse_cnt++;
      got_data.push_back(bus.data_tx);
      got_cyc.push_back(cyc);
      if (auto_tx && have_fall)
        got_gap.push_back(cyc - fall_cyc);
      else
        got_gap.push_back(-1);
      have_fall = 1'b0;
      if (auto_tx) begin
        auto_busy = 1'b1;
        tx_left   = 8;
      end
    end else if (auto_tx && tx_left > 0) begin
      tx_left--;
      if (tx_left == 0) begin
        auto_busy = 1'b0;
        fall_cyc  = cyc;
        have_fall = 1'b1;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    checks++;
    if (bus.count !== 5'd0)
      $display("FAIL rst_count: got %0d want 0", bus.count);
    else passes++;
    checks++;
    if (bus.empty !== 1'b1)
      $display("FAIL rst_empty: got %b want 1", bus.empty);
    else passes++;
    checks++;
    if (bus.full !== 1'b0)
      $display("FAIL rst_full: got %b want 0", bus.full);
    else passes++;
    checks++;
    if (bus.new_data_tx !== 1'b0)
      $display("FAIL rst_ndt: got %b want 0", bus.new_data_tx);
    else passes++;
    checks++;
    if (bus.data_tx !== 8'h00)
      $display("FAIL rst_data: got %02h want 00", bus.data_tx);
    else passes++;
    checks++;
    if (bus.overflow !== 1'b0)
      $display("FAIL rst_ovf: got %b want 0", bus.overflow);
    else passes++;
  endtask

  task automatic test_single();
    int p0;
    p0 = pulse_cnt;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hA5;
    exp_q.push_back(8'hA5);
    step();
    bus.wr_en = 1'b0;
    checks++;
    if (bus.count !== 5'd1)
      $display("FAIL single_cnt1: got %0d want 1", bus.count);
    else passes++;
    checks++;
    if (bus.new_data_tx !== 1'b0)
      $display("FAIL single_early: got %b want 0", bus.new_data_tx);
    else passes++;
    step();
    checks++;
    if (bus.new_data_tx !== 1'b1)
      $display("FAIL single_pulse: got %b want 1", bus.new_data_tx);
    else passes++;
    checks++;
    if (bus.count !== 5'd0)
      $display("FAIL single_cnt0: got %0d want 0", bus.count);
    else passes++;
    busy_lvl = 1'b1;
    repeat (88) step();
    checks++;
    if (pulse_cnt !== p0 + 1)
      $display("FAIL single_npulse: got %0d want %0d", pulse_cnt - p0, 1);
    else passes++;
    checks++;
    if (bus.empty !== 1'b1)
      $display("FAIL single_empty: got %b want 1", bus.empty);
    else passes++;
    checks++;
    if (bus.data_tx !== 8'hA5)
      $display("FAIL single_hold: got %02h want a5", bus.data_tx);
    else passes++;
    busy_lvl = 1'b0;
    repeat (3) step();
    while (gi < got_data.size()) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL single_extra: got %02h want none", got_data[gi]);
      end else begin
        exp_b = exp_q.pop_front();
        if (got_data[gi] !== exp_b)
          $display("FAIL single_byte: got %02h want %02h", got_data[gi], exp_b);
        else passes++;
      end
      gi++;
    end
  endtask

  task automatic test_order_gap();
    int p0;
    int ngap;
    p0 = pulse_cnt;
    ngap = 0;
    auto_tx = 1'b1;
    step();
    for (int i = 1; i <= 3; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(i);
      exp_q.push_back(8'(i));
      step();
    end
    bus.wr_en = 1'b0;
    for (int k = 0; k < 200 && pulse_cnt < p0 + 3; k++)
      step();
    checks++;
    if (pulse_cnt !== p0 + 3)
      $display("FAIL order_timeout: got %0d pulses want 3", pulse_cnt - p0);
    else passes++;
    repeat (12) step();
    auto_tx = 1'b0;
    step();
    while (gi < got_data.size()) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL order_extra: got %02h want none", got_data[gi]);
      end else begin
        exp_b = exp_q.pop_front();
        if (got_data[gi] !== exp_b)
          $display("FAIL order_byte: got %02h want %02h", got_data[gi], exp_b);
        else passes++;
      end
      if (got_gap[gi] >= 0) begin
        ngap++;
        checks++;
        if (got_gap[gi] != 2)
          $display("FAIL order_gap: got %0d cycles want 2", got_gap[gi]);
        else passes++;
      end
      gi++;
    end
    checks++;
    if (ngap != 2)
      $display("FAIL order_ngap: got %0d gaps want 2", ngap);
    else passes++;
  endtask

  task automatic test_full();
    int p0;
    int mcount;
    bit drop;
    p0 = pulse_cnt;
    mcount = 0;
    busy_lvl = 1'b1;
    step();
    for (int i = 0; i <= 16; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(i);
      if (mcount < 16) begin
        exp_q.push_back(8'(i));
        mcount++;
        drop = 1'b0;
      end else begin
        drop = 1'b1;
      end
      step();
      checks++;
      if (bus.full !== (mcount == 16))
        $display("FAIL full_flag: i=%0d got %b want %b", i, bus.full, mcount == 16);
      else passes++;
      checks++;
      if (bus.overflow !== drop)
        $display("FAIL full_ovf: i=%0d got %b want %b", i, bus.overflow, drop);
      else passes++;
      checks++;
      if (bus.count !== 5'(mcount))
        $display("FAIL full_cnt: i=%0d got %0d want %0d", i, bus.count, mcount);
      else passes++;
    end
    bus.wr_en = 1'b0;
    step();
    checks++;
    if (bus.overflow !== 1'b0)
      $display("FAIL full_ovf_pulse: got %b want 0", bus.overflow);
    else passes++;
    checks++;
    if (bus.count !== 5'd16)
      $display("FAIL full_cnt_hold: got %0d want 16", bus.count);
    else passes++;
    busy_lvl = 1'b0;
    for (int k = 0; k < 300 && pulse_cnt < p0 + 16; k++)
      step();
    repeat (20) step();
    checks++;
    if (pulse_cnt !== p0 + 16)
      $display("FAIL full_npulse: got %0d want 16", pulse_cnt - p0);
    else passes++;
    checks++;
    if (bus.empty !== 1'b1)
      $display("FAIL full_drained: got %b want 1", bus.empty);
    else passes++;
    while (gi < got_data.size()) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL full_extra: got %02h want none", got_data[gi]);
      end else begin
        exp_b = exp_q.pop_front();
        if (got_data[gi] !== exp_b)
          $display("FAIL full_byte: got %02h want %02h", got_data[gi], exp_b);
        else passes++;
      end
      gi++;
    end
  endtask

  task automatic test_simul();
    int p0;
    p0 = pulse_cnt;
    busy_lvl = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'h31 + 8'(i);
      exp_q.push_back(8'h31 + 8'(i));
      step();
    end
    bus.wr_en = 1'b0;
    checks++;
    if (bus.count !== 5'd3)
      $display("FAIL simul_pre: got %0d want 3", bus.count);
    else passes++;
    busy_lvl    = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h34;
    exp_q.push_back(8'h34);
    step();
    bus.wr_en = 1'b0;
    checks++;
    if (bus.new_data_tx !== 1'b1)
      $display("FAIL simul_pop: got %b want 1", bus.new_data_tx);
    else passes++;
    checks++;
    if (bus.count !== 5'd3)
      $display("FAIL simul_cnt: got %0d want 3", bus.count);
    else passes++;
    for (int k = 0; k < 100 && pulse_cnt < p0 + 4; k++)
      step();
    repeat (8) step();
    checks++;
    if (pulse_cnt !== p0 + 4)
      $display("FAIL simul_npulse: got %0d want 4", pulse_cnt - p0);
    else passes++;
    while (gi < got_data.size()) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL simul_extra: got %02h want none", got_data[gi]);
      end else begin
        exp_b = exp_q.pop_front();
        if (got_data[gi] !== exp_b)
          $display("FAIL simul_byte: got %02h want %02h", got_data[gi], exp_b);
        else passes++;
      end
      gi++;
    end
  endtask

  task automatic test_timeout();
    int p0;
    int wc;
    int first_c;
    p0 = pulse_cnt;
    busy_lvl = 1'b0;
    first_c = -1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h55;
    exp_q.push_back(8'h55);
    wc = cyc;
    step();
    bus.wr_data = 8'h66;
    exp_q.push_back(8'h66);
    step();
    bus.wr_en = 1'b0;
    for (int k = 0; k < 50 && pulse_cnt < p0 + 2; k++)
      step();
    repeat (8) step();
    checks++;
    if (pulse_cnt !== p0 + 2)
      $display("FAIL tmo_npulse: got %0d want 2", pulse_cnt - p0);
    else passes++;
    while (gi < got_data.size()) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL tmo_extra: got %02h want none", got_data[gi]);
      end else begin
        exp_b = exp_q.pop_front();
        if (got_data[gi] !== exp_b) begin
          $display("FAIL tmo_byte: got %02h want %02h", got_data[gi], exp_b);
        end else begin
          passes++;
          checks++;
          if (exp_b == 8'h55) begin
            first_c = got_cyc[gi];
            if (got_cyc[gi] != wc + 2)
              $display("FAIL tmo_lat: got %0d want %0d", got_cyc[gi] - wc, 2);
            else passes++;
          end else begin
            if (got_cyc[gi] - first_c != 5)
              $display("FAIL tmo_gap: got %0d want 5", got_cyc[gi] - first_c);
            else passes++;
          end
        end
      end
      gi++;
    end
  endtask

  task automatic test_reset_mid();
    int p1;
    busy_lvl = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'h80 + 8'(i);
      exp_q.push_back(8'h80 + 8'(i));
      step();
      if (bus.new_data_tx === 1'b1)
        busy_lvl = 1'b1;
    end
    bus.wr_en = 1'b0;
    step();
    checks++;
    if (bus.count !== 5'd5)
      $display("FAIL rmid_pre: got %0d want 5", bus.count);
    else passes++;
    while (gi < got_data.size()) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL rmid_extra: got %02h want none", got_data[gi]);
      end else begin
        exp_b = exp_q.pop_front();
        if (got_data[gi] !== exp_b)
          $display("FAIL rmid_byte: got %02h want %02h", got_data[gi], exp_b);
        else passes++;
      end
      gi++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    checks++;
    if (bus.count !== 5'd0)
      $display("FAIL rmid_cnt: got %0d want 0", bus.count);
    else passes++;
    checks++;
    if (bus.new_data_tx !== 1'b0)
      $display("FAIL rmid_ndt: got %b want 0", bus.new_data_tx);
    else passes++;
    checks++;
    if (bus.data_tx !== 8'h00)
      $display("FAIL rmid_data: got %02h want 00", bus.data_tx);
    else passes++;
    p1 = pulse_cnt;
    repeat (10) step();
    busy_lvl = 1'b0;
    repeat (20) step();
    checks++;
    if (pulse_cnt !== p1)
      $display("FAIL rmid_quiet: got %0d pulses want 0", pulse_cnt - p1);
    else passes++;
    busy_lvl    = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h77;
    exp_q.push_back(8'h77);
    step();
    bus.wr_en = 1'b0;
    repeat (10) step();
    checks++;
    if (pulse_cnt !== p1)
      $display("FAIL rmid_defer: got %0d pulses want 0", pulse_cnt - p1);
    else passes++;
    busy_lvl = 1'b0;
    for (int k = 0; k < 20 && pulse_cnt < p1 + 1; k++)
      step();
    repeat (8) step();
    checks++;
    if (pulse_cnt !== p1 + 1)
      $display("FAIL rmid_post: got %0d pulses want 1", pulse_cnt - p1);
    else passes++;
    while (gi < got_data.size()) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL rmid_extra2: got %02h want none", got_data[gi]);
      end else begin
        exp_b = exp_q.pop_front();
        if (got_data[gi] !== exp_b)
          $display("FAIL rmid_byte2: got %02h want %02h", got_data[gi], exp_b);
        else passes++;
      end
      gi++;
    end
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    rst         = 1'b1;
    test_reset();
    repeat (5) step();
    test_single();
    test_order_gap();
    test_full();
    test_simul();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
